cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
Run/step controller sitting directly downstream of the board clock divider, in the out_clk domain. It samples the divider's slow square wave and converts each rising edge into a one-cycle CPU clock-enable pulse. It gates that pulse by run/halt mode and a debounced single-step push button, and counts issued steps. The single-cycle CPU and its display logic consume cpu_en and step_count.

Parameters:
DEBOUNCE_CYCLES, 1000000, out_clk cycles the synchronised button must hold a new level before it is accepted (20 ms at 50 MHz); legal range 2 to 2^DB_W-1
DB_W, 20, debounce counter width
STEP_W, 16, step counter width

Ports:
out_clk  input  1  board clock; the only clock in this block
reset_n  input  1  synchronous active-low reset
div_clk  input  1  divided clock from the divider; treated as asynchronous, synchronised internally
btn_step  input  1  raw single-step push button, active-high, bouncy, asynchronous
sw_run  input  1  raw run switch: 1 = free-run, 0 = halt; asynchronous
cpu_en  output  1  one-out_clk-cycle CPU enable pulse; registered
mode  output  2  current state: 00 HALT, 01 RUN, 10 STEP; 11 never driven
step_count  output  STEP_W  number of cpu_en pulses issued since reset; wraps

Behaviour:
- Reset: any out_clk rising edge with reset_n=0 clears all state. cpu_en=0, mode=00 (HALT), step_count=0. Synchroniser flops, edge-detect flop, debounce counter and stable button level all clear to 0. Applies mid-operation; a pending STEP is discarded.
- Synchronisers: div_clk, btn_step and sw_run each pass through two flops (s1, s2). div_clk has a third flop (s3). div_tick = s2 & ~s3 (combinational).
- Debounce: the block holds btn_stable and a DB_W counter.
  - If synced btn equals btn_stable, the counter clears to 0.
  - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1, btn_stable takes the synced value and the counter clears on the same edge.
  - press = btn_stable rising, registered as a one-cycle event.
  - Release causes no action. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- State machine (registered):
  - HALT: if synced sw_run=1, go to RUN. Else if press, go to STEP. sw_run has priority when both occur on the same edge.
  - RUN: cpu_en <= div_tick. If synced sw_run=0, go to HALT; a div_tick on that same edge still issues its pulse. Presses are ignored.
  - STEP: wait for div_tick. On it, cpu_en <= 1 for exactly one cycle and go to HALT. Further presses while in STEP are ignored. sw_run=1 in STEP takes effect only after the step issues (STEP -> HALT -> RUN).
- cpu_en: high for exactly one out_clk cycle per accepted div_clk rising edge. Never high in two consecutive cycles.
- Latency: with div_clk rising between two out_clk edges, cpu_en is high in the cycle following the 3rd out_clk edge after the rise (2 sync + 1 output register).
- step_count: increments by 1 on the edge after each cycle in which cpu_en=1. Modulo 2^STEP_W; 2^STEP_W-1 wraps to 0.
- div_clk held constant: no cpu_en in any mode.

Test Plan:
Setup for all scenarios: DEBOUNCE_CYCLES=4, div_clk period 20 out_clk cycles.
1. Reset: hold reset_n=0 for 3 cycles while all inputs toggle -> cpu_en=0, mode=00, step_count=0 throughout and on release.
2. Free-run: sw_run=1 for 200 cycles -> mode=01 by the 3rd edge. 10 cpu_en pulses, each 1 cycle wide, 3 edges after each div_clk rise. step_count=10.
3. Single step:
   - sw_run=0; btn_step high with 2-cycle bounces, then stable for 10 cycles -> exactly one press.
   - mode=10 until the next div_tick, then one cpu_en pulse and mode=00. step_count increments by 1.
   - A 3-cycle btn glitch -> no step.
4. Simultaneous events:
   - In HALT, sw_run rise and press land on the same edge -> mode=01, not 10.
   - Second press during STEP -> still exactly one pulse.
5. Reset mid-STEP: assert reset_n=0 while mode=10, before div_tick -> no cpu_en, mode=00, step_count=0.
6. Wrap: run with STEP_W=4 for 17 div_clk periods -> step_count sequence ..., 15, 0, 1.

Source files
------------

// File: rtl/cpu_step_ctrl_if.sv
// cpu_step_ctrl_if: board-side inputs and CPU-side outputs of the run/step controller
interface cpu_step_ctrl_if #(parameter int STEP_W = 16);
    logic              div_clk;
    logic              btn_step;
    logic              sw_run;
    logic              cpu_en;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step_count;
    modport master (output div_clk, btn_step, sw_run, input cpu_en, mode, step_count);
    modport slave  (input div_clk, btn_step, sw_run, output cpu_en, mode, step_count);
endinterface

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns divided-clock rising edges into one-cycle CPU enables, gated by run/halt/step mode
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20,
    parameter int STEP_W          = 16
) (
    input logic           out_clk,
    input logic           reset_n,
    cpu_step_ctrl_if.slave bus
);
    typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10} state_t;
    state_t            state;
    logic              div_s1, div_s2, div_s3;
    logic              btn_s1, btn_s2;
    logic              run_s1, run_s2;
    logic              btn_stable, press, cpu_en;
    logic [DB_W-1:0]   db_cnt;
    logic [STEP_W-1:0] step_count;
    logic              div_tick, db_done;
    assign div_tick = div_s2 & ~div_s3;
    assign db_done  = db_cnt == DB_W'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge out_clk) begin
        if (!reset_n) begin
            {div_s1, div_s2, div_s3} <= '0;
            {btn_s1, btn_s2, run_s1, run_s2} <= '0;
            btn_stable <= 1'b0;
            press      <= 1'b0;
            db_cnt     <= '0;
            cpu_en     <= 1'b0;
            step_count <= '0;
            state      <= HALT;
        end else begin
            {div_s1, div_s2, div_s3} <= {bus.div_clk, div_s1, div_s2};
            {btn_s1, btn_s2} <= {bus.btn_step, btn_s1};
            {run_s1, run_s2} <= {bus.sw_run, run_s1};
            press <= 1'b0;
            // a new level must persist DEBOUNCE_CYCLES cycles; only an accepted rise is a press
            if (btn_s2 == btn_stable)
                db_cnt <= '0;
            else if (db_done) begin
                btn_stable <= btn_s2;
                db_cnt     <= '0;
                press      <= btn_s2;
            end else
                db_cnt <= db_cnt + 1'b1;
            step_count <= step_count + STEP_W'(cpu_en);
            case (state)
                HALT: begin
                    cpu_en <= 1'b0;
                    state  <= run_s2 ? RUN : press ? STEP : HALT;
                end
                RUN: begin
                    cpu_en <= div_tick;
                    state  <= run_s2 ? RUN : HALT;
                end
                STEP: begin
                    cpu_en <= div_tick;
                    state  <= div_tick ? HALT : STEP;
                end
                default: begin
                    cpu_en <= 1'b0;
                    state  <= HALT;
                end
            endcase
        end
    end
    assign bus.cpu_en     = cpu_en;
    assign bus.mode       = state;
    assign bus.step_count = step_count;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: scoreboard bench; each accepted div_clk rise queues the cycle and count of its expected cpu_en pulse
module tb_cpu_step_ctrl;
    localparam int STEP_W = 4;
    typedef struct {int cyc; int cnt;} exp_t;
    logic out_clk = 1'b0;
    logic reset_n = 1'b0;
    cpu_step_ctrl_if #(.STEP_W(STEP_W)) bus ();
    cpu_step_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(20), .STEP_W(STEP_W)) dut (
        .out_clk(out_clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );
    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0, phase = 0, exp_cnt = 0, n_chk = 0, n_fail = 0;
    bit   div_on = 0, run_flag = 0, step_armed = 0, prev_en = 0;
    always #5 out_clk = ~out_clk;
    always @(posedge out_clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask
    // div_clk has a 20-cycle period; its rise lands 2 time units after an out_clk edge
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge out_clk);
            #2;
            if (div_on) begin
                if (phase == 0 && !bus.div_clk && reset_n && (run_flag || step_armed)) begin
                    q.push_back('{cyc: cyc + 3, cnt: exp_cnt});
                    exp_cnt    = (exp_cnt + 1) % (1 << STEP_W);
                    step_armed = 0;
                end
                bus.div_clk = phase < 10;
                phase = (phase + 1) % 20;
            end
        end
    endtask
    task automatic to_phase(input int p);
        for (int i = 0; i < 20 && phase != p; i++) tick();
    endtask
    always @(negedge out_clk) begin
        if (bus.cpu_en === 1'b1) begin
            chk("en_width", prev_en, 0);
            if (q.size() == 0)
                chk("spurious_en", 1, 0);
            else begin
                mon_e = q.pop_front();
                chk("en_cycle", cyc, mon_e.cyc);
                chk("en_count", bus.step_count, mon_e.cnt);
            end
        end
        prev_en = bus.cpu_en === 1'b1;
    end
    initial begin
        bus.div_clk = 0; bus.btn_step = 0; bus.sw_run = 0;
        for (int i = 0; i < 3; i++) begin
            bus.div_clk = ~bus.div_clk; bus.btn_step = ~bus.btn_step; bus.sw_run = ~bus.sw_run;
            tick();
            chk("rst_en", bus.cpu_en, 0);
            chk("rst_mode", bus.mode, 0);
            chk("rst_cnt", bus.step_count, 0);
        end
        bus.div_clk = 0; bus.btn_step = 0; bus.sw_run = 0;
        reset_n = 1;
        tick(3);
        chk("rel_en", bus.cpu_en, 0);
        chk("rel_mode", bus.mode, 0);
        chk("rel_cnt", bus.step_count, 0);
        phase = 10; div_on = 1;
        to_phase(5);
        bus.sw_run = 1; run_flag = 1;
        tick(3);
        chk("run_mode", bus.mode, 1);
        tick(200);
        chk("run_cnt", bus.step_count, 10);
        to_phase(5);
        bus.sw_run = 0; run_flag = 0;
        tick(3);
        chk("halt_mode", bus.mode, 0);
        tick(40);
        to_phase(12); div_on = 0;
        for (int i = 0; i < 8; i++) begin
            bus.btn_step = (i % 4) < 2;
            tick();
        end
        bus.btn_step = 1;
        tick(10);
        chk("step_mode", bus.mode, 2);
        bus.btn_step = 0;
        tick(20);
        chk("step_hold", bus.mode, 2);
        bus.btn_step = 1;
        tick(8);
        bus.btn_step = 0;
        tick(12);
        chk("step_hold2", bus.mode, 2);
        step_armed = 1; div_on = 1;
        tick(15);
        chk("step_done", bus.mode, 0);
        chk("step_cnt", bus.step_count, exp_cnt);
        tick(40);
        to_phase(12); div_on = 0;
        bus.btn_step = 1;
        tick(3);
        bus.btn_step = 0;
        tick(15);
        chk("glitch_mode", bus.mode, 0);
        div_on = 1;
        tick(40);
        chk("glitch_cnt", bus.step_count, exp_cnt);
        to_phase(12); div_on = 0;
        bus.btn_step = 1;
        tick(4);
        bus.sw_run = 1; run_flag = 1;
        tick(3);
        chk("simul_mode", bus.mode, 1);
        tick(5);
        chk("simul_mode2", bus.mode, 1);
        bus.btn_step = 0;
        tick(10);
        chk("simul_mode3", bus.mode, 1);
        bus.sw_run = 0; run_flag = 0;
        tick(5);
        chk("simul_halt", bus.mode, 0);
        bus.btn_step = 1;
        tick(8);
        bus.btn_step = 0;
        chk("pre_rst_mode", bus.mode, 2);
        tick(8);
        reset_n = 0;
        tick(2);
        chk("mid_rst_en", bus.cpu_en, 0);
        chk("mid_rst_mode", bus.mode, 0);
        chk("mid_rst_cnt", bus.step_count, 0);
        reset_n = 1; exp_cnt = 0;
        div_on = 1;
        tick(40);
        chk("post_rst_mode", bus.mode, 0);
        chk("post_rst_cnt", bus.step_count, 0);
        to_phase(5);
        bus.sw_run = 1; run_flag = 1;
        tick(340);
        chk("wrap_cnt", bus.step_count, 1);
        to_phase(5);
        bus.sw_run = 0; run_flag = 0;
        tick(10);
        chk("final_mode", bus.mode, 0);
        chk("pending", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
